conv_core_ctrl: RTL and testbench

Sequencer for one convolution_core instance (8 PE arrays plus adder trees).
- Loads the 3*3 weight sets into each of the 8 PE arrays in turn through the one-hot weight_valid bus.
- Issues the bias/adder-feature load, then gates feature beats into pulse.
- Produces out_valid aligned to the core's fixed pipeline latency and signals done.
- Sits between the weight/feature buffer readers and convolution_core in the conv engine.

---
 rtl/conv_core_ctrl_pkg.sv | 21 ++
 rtl/conv_valid_delay.sv | 32 +++
 rtl/conv_core_ctrl.sv | 140 ++++++++++++++
 tb/tb_conv_core_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_core_ctrl_pkg.sv
// Shared constants and FSM encoding for the convolution core sequencer.
// Sizes follow one core: 8 PE arrays of 3x3 PEs.
package conv_core_ctrl_pkg;

  localparam int PE_NUM_PRE_CORE = 3;
  localparam int PE_CORE_NUM     = 8;
  localparam int PE_ARRAY_NUM    = PE_CORE_NUM;
  localparam int WEIGHT_BEATS    = PE_NUM_PRE_CORE * PE_NUM_PRE_CORE;
  localparam int PIX_CNT_WIDTH   = 16;
  localparam int PIPE_LAT        = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_B,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/conv_valid_delay.sv
// Delay line that tracks feature beats through the core pipeline.
// Produces out_valid and a flag telling DRAIN no beat is left behind it.
module conv_valid_delay
  import conv_core_ctrl_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pulse_i,
  output logic valid_o,
  output logic empty_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  assign sr_d = {sr_q[DEPTH-2:0], pulse_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid_o = sr_q[DEPTH-1];
  // Only the beat leaving this cycle may remain.
  assign empty_o = ~|sr_q[DEPTH-2:0];

endmodule

// File: rtl/conv_core_ctrl.sv
// Sequencer for one convolution core: weight load, bias load,
// feature streaming and pipeline drain with completion pulse.
module conv_core_ctrl
  import conv_core_ctrl_pkg::*;
(
  input  logic                     DSP_clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PIX_CNT_WIDTH-1:0] cfg_pixel_num,
  input  logic                     cfg_bias_or_adder,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic                     bias_in_valid,
  output logic                     bias_ready,
  input  logic                     feat_valid,
  output logic                     feat_ready,
  output logic [PE_ARRAY_NUM-1:0]  weight_valid,
  output logic                     bias_valid,
  output logic                     bias_or_adder_feature,
  output logic                     pulse,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(PE_ARRAY_NUM);
  localparam int BW = $clog2(WEIGHT_BEATS);

  state_e state_q, state_d;
  logic [AW-1:0] arr_q, arr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [PIX_CNT_WIDTH-1:0] pix_q, pix_d;
  logic [PIX_CNT_WIDTH-1:0] cfg_pix_q, cfg_pix_d;
  logic bsel_q, bsel_d;
  logic dly_empty;

  always_ff @(posedge DSP_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      arr_q     <= '0;
      beat_q    <= '0;
      pix_q     <= '0;
      cfg_pix_q <= '0;
      bsel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arr_q     <= arr_d;
      beat_q    <= beat_d;
      pix_q     <= pix_d;
      cfg_pix_q <= cfg_pix_d;
      bsel_q    <= bsel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    arr_d        = arr_q;
    beat_d       = beat_q;
    pix_d        = pix_q;
    cfg_pix_d    = cfg_pix_q;
    bsel_d       = bsel_q;
    w_ready      = 1'b0;
    bias_ready   = 1'b0;
    feat_ready   = 1'b0;
    weight_valid = '0;
    bias_valid   = 1'b0;
    pulse        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_pix_d = cfg_pixel_num;
          bsel_d    = cfg_bias_or_adder;
          arr_d     = '0;
          beat_d    = '0;
          pix_d     = '0;
          state_d   = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          weight_valid = PE_ARRAY_NUM'(1) << arr_q;
          if (beat_q == BW'(WEIGHT_BEATS - 1)) begin
            beat_d = '0;
            arr_d  = arr_q + 1'b1;
            if (arr_q == AW'(PE_ARRAY_NUM - 1)) begin
              state_d = S_LOAD_B;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        bias_ready = 1'b1;
        if (bias_in_valid) begin
          bias_valid = 1'b1;
          state_d = (cfg_pix_q == '0) ? S_DRAIN : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        feat_ready = 1'b1;
        if (feat_valid) begin
          pulse = 1'b1;
          pix_d = pix_q + 1'b1;
          // Compare against count-1 so the full-range count never wraps.
          if (pix_q == cfg_pix_q - 1'b1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (dly_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  conv_valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_valid_delay (
    .clk_i   (DSP_clk),
    .rst_ni  (rst_n),
    .pulse_i (pulse),
    .valid_o (out_valid),
    .empty_o (dly_empty)
  );

  assign busy                  = (state_q != S_IDLE);
  assign done                  = (state_q == S_DONE);
  assign bias_or_adder_feature = bsel_q;

endmodule

// File: tb/tb_conv_core_ctrl.sv
// Directed bench for conv_core_ctrl: per-layer vector table plus
// hand-written reset-abort sequence, with a per-cycle protocol monitor.
module tb_conv_core_ctrl;
  import conv_core_ctrl_pkg::*;

  logic                     DSP_clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [PIX_CNT_WIDTH-1:0] cfg_pixel_num = '0;
  logic                     cfg_bias_or_adder = 1'b0;
  logic                     w_valid = 1'b0;
  logic                     w_ready;
  logic                     bias_in_valid = 1'b0;
  logic                     bias_ready;
  logic                     feat_valid = 1'b0;
  logic                     feat_ready;
  logic [PE_ARRAY_NUM-1:0]  weight_valid;
  logic                     bias_valid;
  logic                     bias_or_adder_feature;
  logic                     pulse;
  logic                     out_valid;
  logic                     busy;
  logic                     done;

  always #5 DSP_clk = ~DSP_clk;

  conv_core_ctrl dut (
    .DSP_clk               (DSP_clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .cfg_pixel_num         (cfg_pixel_num),
    .cfg_bias_or_adder     (cfg_bias_or_adder),
    .w_valid               (w_valid),
    .w_ready               (w_ready),
    .bias_in_valid         (bias_in_valid),
    .bias_ready            (bias_ready),
    .feat_valid            (feat_valid),
    .feat_ready            (feat_ready),
    .weight_valid          (weight_valid),
    .bias_valid            (bias_valid),
    .bias_or_adder_feature (bias_or_adder_feature),
    .pulse                 (pulse),
    .out_valid             (out_valid),
    .busy                  (busy),
    .done                  (done)
  );

  typedef struct {
    logic [PIX_CNT_WIDTH-1:0] pix;
    logic sel;
    bit   wtog;
    int   stall_at;
    int   stall_len;
    bit   ign;
    bit   b2b;
    int   e_whs;
    int   e_bias;
    int   e_pulse;
    int   e_ov;
  } vec_t;

  localparam int NV = 6;
  localparam int BUDGET = 3000;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_whs, n_bias, n_pulse, n_ov, n_done, n_fr;
  int done_cyc, last_ov_cyc, bias_cyc;
  int arr_cnt[PE_ARRAY_NUM];
  logic [PIPE_LAT-1:0] phist = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_counts();
    n_whs = 0; n_bias = 0; n_pulse = 0; n_ov = 0;
    n_done = 0; n_fr = 0;
    done_cyc = -1; last_ov_cyc = -1; bias_cyc = -1;
    for (int i = 0; i < PE_ARRAY_NUM; i++) arr_cnt[i] = 0;
  endtask

  // phist[k] holds the pulse seen k+1 cycles ago.
  always @(negedge DSP_clk) begin
    cyc++;
    if (!rst_n) begin
      phist = '0;
    end else begin
      chk("out_valid_lat", 32'(out_valid), 32'(phist[PIPE_LAT-1]));
      chk("strobe_excl",
          32'($countones({|weight_valid, bias_valid, pulse}) <= 1), 1);
      chk("ready_excl", 32'($onehot0({w_ready, bias_ready, feat_ready})), 1);
      if (weight_valid != '0) begin
        chk("weight_valid",
            32'(weight_valid),
            32'(PE_ARRAY_NUM'(1) << (n_whs / WEIGHT_BEATS)));
        chk("wv_needs_w_valid", 32'(w_valid), 1);
        n_whs++;
        for (int i = 0; i < PE_ARRAY_NUM; i++)
          if (weight_valid[i]) arr_cnt[i]++;
      end
      if (bias_valid) begin
        chk("bv_needs_in_valid", 32'(bias_in_valid), 1);
        n_bias++;
        bias_cyc = cyc;
      end
      if (pulse) begin
        chk("pulse_needs_valid", 32'(feat_valid), 1);
        n_pulse++;
      end
      if (out_valid) begin
        n_ov++;
        last_ov_cyc = cyc;
      end
      if (feat_ready) n_fr++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      phist = {phist[PIPE_LAT-2:0], pulse};
    end
  end

  task automatic run_layer(input vec_t v, input bit next_b2b);
    int c;
    bit arr_ok;
    reset_counts();
    start = 1'b1;
    cfg_pixel_num = v.pix;
    cfg_bias_or_adder = v.sel;
    w_valid = 1'b0;
    bias_in_valid = 1'b0;
    feat_valid = 1'b0;
    @(posedge DSP_clk); #1;
    start = 1'b0;
    cfg_pixel_num = v.pix + 16'd5;
    cfg_bias_or_adder = ~v.sel;
    chk("latched_sel", 32'(bias_or_adder_feature), 32'(v.sel));
    chk("enter_load_w", 32'({busy, w_ready}), 32'(2'b11));
    c = 0;
    while (n_done == 0 && c < BUDGET) begin
      w_valid = v.wtog ? (cyc % 2 == 0) : 1'b1;
      bias_in_valid = 1'b1;
      feat_valid = !(v.stall_len > 0 && n_fr >= v.stall_at &&
                     n_fr < v.stall_at + v.stall_len);
      start = v.ign && ((n_whs == 20) || (n_pulse == 1));
      @(posedge DSP_clk); #1;
      c++;
    end
    start = 1'b0;
    w_valid = 1'b0;
    bias_in_valid = 1'b0;
    feat_valid = 1'b0;
    chk("done_in_budget", 32'(c < BUDGET), 1);
    chk("weight_hs", n_whs, v.e_whs);
    arr_ok = 1'b1;
    for (int i = 0; i < PE_ARRAY_NUM; i++)
      if (arr_cnt[i] != WEIGHT_BEATS) arr_ok = 1'b0;
    chk("beats_per_array", 32'(arr_ok), 1);
    chk("bias_strobes", n_bias, v.e_bias);
    chk("pulses", n_pulse, v.e_pulse);
    chk("out_valids", n_ov, v.e_ov);
    chk("done_count", n_done, 1);
    if (v.pix != '0)
      chk("done_after_last_ov", done_cyc, last_ov_cyc + 1);
    else
      chk("done_after_bias", done_cyc, bias_cyc + 2);
    if (!next_b2b) begin
      chk("idle_after_done", 32'({busy, done}), 0);
      repeat (3) begin
        @(posedge DSP_clk); #1;
      end
      chk("single_done", n_done, 1);
    end
  endtask

  vec_t vecs[NV];

  initial begin
    int c;
    // pix sel wtog stall_at stall_len ign b2b | whs bias pulse ov
    vecs[0] = '{16'd4,  1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 72, 1, 4,  4};
    vecs[1] = '{16'd4,  1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 72, 1, 4,  4};
    vecs[2] = '{16'd0,  1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 72, 1, 0,  0};
    vecs[3] = '{16'd10, 1'b0, 1'b0, 4, 3, 1'b0, 1'b0, 72, 1, 10, 10};
    vecs[4] = '{16'd3,  1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 72, 1, 3,  3};
    vecs[5] = '{16'd2,  1'b0, 1'b1, 1, 2, 1'b0, 1'b1, 72, 1, 2,  2};
    reset_counts();

    #2;
    chk("reset_outputs",
        32'({weight_valid, bias_valid, pulse, out_valid, busy, done,
             w_ready, bias_ready, feat_ready, bias_or_adder_feature}), 0);
    repeat (2) @(posedge DSP_clk);
    #1;
    rst_n = 1'b1;
    @(posedge DSP_clk); #1;
    chk("idle_after_reset", 32'({busy, w_ready, out_valid}), 0);

    for (int i = 0; i < NV; i++)
      run_layer(vecs[i], (i + 1 < NV) ? vecs[i+1].b2b : 1'b0);

    // Abort a layer in COMPUTE after two pulses.
    reset_counts();
    start = 1'b1;
    cfg_pixel_num = 16'd10;
    cfg_bias_or_adder = 1'b1;
    @(posedge DSP_clk); #1;
    start = 1'b0;
    c = 0;
    while (n_pulse < 2 && c < 500) begin
      w_valid = 1'b1;
      bias_in_valid = 1'b1;
      feat_valid = 1'b1;
      @(posedge DSP_clk); #1;
      c++;
    end
    chk("abort_two_pulses", 32'(c < 500), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero",
        32'({weight_valid, bias_valid, pulse, out_valid, busy, done,
             w_ready, bias_ready, feat_ready, bias_or_adder_feature}), 0);
    @(posedge DSP_clk); #1;
    rst_n = 1'b1;
    w_valid = 1'b0;
    bias_in_valid = 1'b0;
    feat_valid = 1'b0;
    repeat (10) begin
      @(posedge DSP_clk); #1;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_no_out_valid", n_ov, 0);
    chk("abort_idle", 32'(busy), 0);
    run_layer(vecs[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
